// File: rtl/alu_issue_buffer_if.sv
// alu_issue_buffer_if: dispatch, result-broadcast and issue signals of the ALU reservation buffer
interface alu_issue_buffer_if;
  logic [31:0] ALU_Instr;
  logic [31:0] ALU_InstrNO;
  logic        ALU_DR;
  logic [31:0] src1_tag;
  logic        src1_pend;
  logic [31:0] src2_tag;
  logic        src2_pend;
  logic        cdb_valid;
  logic [31:0] cdb_tag;
  logic        flush;
  logic        ALUbuffer_ready;
  logic        iss_valid;
  logic [31:0] iss_instr;
  logic [31:0] iss_instr_no;
  logic        iss_ready;
  logic [3:0]  occupancy;
  modport master (
    output ALU_Instr, ALU_InstrNO, ALU_DR, src1_tag, src1_pend, src2_tag, src2_pend,
           cdb_valid, cdb_tag, flush, iss_ready,
    input  ALUbuffer_ready, iss_valid, iss_instr, iss_instr_no, occupancy
  );
  modport slave (
    input  ALU_Instr, ALU_InstrNO, ALU_DR, src1_tag, src1_pend, src2_tag, src2_pend,
           cdb_valid, cdb_tag, flush, iss_ready,
    output ALUbuffer_ready, iss_valid, iss_instr, iss_instr_no, occupancy
  );
endinterface

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: age-compacting reservation queue feeding the ALU through a registered issue port
module alu_issue_buffer #(parameter int DEPTH = 4) (
  input logic clk,
  input logic rst,
  alu_issue_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] no;
    logic [31:0] tag1;
    logic        pend1;
    logic [31:0] tag2;
    logic        pend2;
  } entry_t;
  entry_t           r_q [DEPTH];
  logic [3:0]       r_occ;
  logic             r_iss_valid;
  logic [31:0]      r_iss_instr;
  logic [31:0]      r_iss_no;
  entry_t           w_q [DEPTH];
  entry_t           w_src;
  entry_t           w_new;
  logic [DEPTH-1:0] w_rdy;
  logic [AW-1:0]    w_sel;
  logic [3:0]       w_cnt;
  logic             w_any;
  logic             w_load;
  logic             w_disp;
  assign bus.ALUbuffer_ready = (r_occ < 4'(DEPTH)) && !bus.flush;
  assign bus.iss_valid       = r_iss_valid;
  assign bus.iss_instr       = r_iss_instr;
  assign bus.iss_instr_no    = r_iss_no;
  assign bus.occupancy       = r_occ;
  assign w_disp = bus.ALU_DR && bus.ALUbuffer_ready;
  assign w_load = w_any && (!r_iss_valid || bus.iss_ready);
  assign w_cnt  = r_occ - {3'b0, w_load};
  // Readiness uses the registered pend bits, so a broadcast only enables issue on the next edge.
  for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
    assign w_rdy[g] = (4'(g) < r_occ) && !r_q[g].pend1 && !r_q[g].pend2;
  end
  assign w_new = '{
    instr: bus.ALU_Instr,
    no:    bus.ALU_InstrNO,
    tag1:  bus.src1_tag,
    pend1: bus.src1_pend && !(bus.cdb_valid && bus.cdb_tag == bus.src1_tag),
    tag2:  bus.src2_tag,
    pend2: bus.src2_pend && !(bus.cdb_valid && bus.cdb_tag == bus.src2_tag)
  };
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_sel = w_rdy[i] ? AW'(i) : w_sel;
      w_any = w_any || w_rdy[i];
    end
  end
  // Compact above the removed slot, apply wakeup, then drop the new entry at the compacted tail.
  always_comb begin
    w_src = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_src       = (w_load && i >= int'(w_sel)) ? r_q[(i < DEPTH - 1) ? i + 1 : i] : r_q[i];
      w_src.pend1 = w_src.pend1 && !(bus.cdb_valid && bus.cdb_tag == w_src.tag1);
      w_src.pend2 = w_src.pend2 && !(bus.cdb_valid && bus.cdb_tag == w_src.tag2);
      w_q[i]      = (w_disp && i == int'(w_cnt)) ? w_new : w_src;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_occ       <= '0;
      r_iss_valid <= 1'b0;
      r_iss_instr <= '0;
      r_iss_no    <= '0;
    end else if (bus.flush) begin
      r_occ       <= '0;
      r_iss_valid <= 1'b0;
    end else begin
      r_q   <= w_q;
      r_occ <= w_cnt + {3'b0, w_disp};
      if (w_load) begin
        r_iss_valid <= 1'b1;
        r_iss_instr <= r_q[w_sel].instr;
        r_iss_no    <= r_q[w_sel].no;
      end else if (bus.iss_ready) begin
        r_iss_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_buffer.sv
// tb_alu_issue_buffer: directed checks of dispatch, wakeup, out-of-order issue, backpressure, flush and reset
module tb_alu_issue_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  alu_issue_buffer_if bus ();
  alu_issue_buffer #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [31:0] no, input logic [31:0] t1, input logic p1);
    bus.ALU_DR      = 1'b1;
    bus.ALU_Instr   = 32'h1000 + no;
    bus.ALU_InstrNO = no;
    bus.src1_tag    = t1;
    bus.src1_pend   = p1;
    bus.src2_tag    = 32'h0;
    bus.src2_pend   = 1'b0;
  endtask

  initial begin
    bus.ALU_DR = 1'b0; bus.ALU_Instr = '0; bus.ALU_InstrNO = '0;
    bus.src1_tag = '0; bus.src1_pend = 1'b0; bus.src2_tag = '0; bus.src2_pend = 1'b0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.flush = 1'b0; bus.iss_ready = 1'b0;
    #2;
    chk("rst_occ", 32'(bus.occupancy), 0);
    chk("rst_iss_valid", 32'(bus.iss_valid), 0);
    chk("rst_iss_instr", bus.iss_instr, 0);
    chk("rst_iss_no", bus.iss_instr_no, 0);
    #10 rst = 1'b1;
    #1 chk("rst_ready", 32'(bus.ALUbuffer_ready), 1);

    // basic issue
    disp(5, 0, 0);
    bus.ALU_Instr = 32'h0022_1820;
    bus.iss_ready = 1'b1;
    tick();
    bus.ALU_DR = 1'b0;
    chk("t1_occ_after_disp", 32'(bus.occupancy), 1);
    chk("t1_valid_not_yet", 32'(bus.iss_valid), 0);
    tick();
    chk("t1_valid", 32'(bus.iss_valid), 1);
    chk("t1_no", bus.iss_instr_no, 5);
    chk("t1_instr", bus.iss_instr, 32'h0022_1820);
    chk("t1_occ", 32'(bus.occupancy), 0);
    tick();
    chk("t1_drain", 32'(bus.iss_valid), 0);

    // dependency wait
    disp(7, 3, 1);
    tick();
    bus.ALU_DR = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_wait_valid", 32'(bus.iss_valid), 0);
      chk("t2_wait_occ", 32'(bus.occupancy), 1);
    end
    bus.cdb_valid = 1'b1; bus.cdb_tag = 3;
    tick();
    bus.cdb_valid = 1'b0;
    chk("t2_bcast_edge", 32'(bus.iss_valid), 0);
    tick();
    chk("t2_valid", 32'(bus.iss_valid), 1);
    chk("t2_no", bus.iss_instr_no, 7);
    tick();
    chk("t2_drain", 32'(bus.iss_valid), 0);

    // out-of-order pass
    disp(10, 9, 1);
    tick();
    disp(11, 0, 0);
    tick();
    bus.ALU_DR = 1'b0;
    chk("t3_occ2", 32'(bus.occupancy), 2);
    tick();
    chk("t3_first_no", bus.iss_instr_no, 11);
    chk("t3_first_valid", 32'(bus.iss_valid), 1);
    chk("t3_occ1", 32'(bus.occupancy), 1);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 9;
    tick();
    bus.cdb_valid = 1'b0;
    chk("t3_gap_valid", 32'(bus.iss_valid), 0);
    tick();
    chk("t3_second_no", bus.iss_instr_no, 10);
    chk("t3_occ0", 32'(bus.occupancy), 0);
    tick();

    // full queue and backpressure
    bus.iss_ready = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      disp(32'(t), 0, 0);
      tick();
    end
    bus.ALU_DR = 1'b0;
    chk("t4_occ_full", 32'(bus.occupancy), 4);
    chk("t4_not_ready", 32'(bus.ALUbuffer_ready), 0);
    chk("t4_out_no", bus.iss_instr_no, 1);
    chk("t4_out_valid", 32'(bus.iss_valid), 1);
    disp(6, 0, 0);
    tick();
    bus.ALU_DR = 1'b0;
    chk("t4_drop_occ", 32'(bus.occupancy), 4);
    chk("t4_hold_no", bus.iss_instr_no, 1);
    bus.iss_ready = 1'b1;
    for (int t = 2; t <= 5; t++) begin
      tick();
      chk("t4_order", bus.iss_instr_no, 32'(t));
      chk("t4_order_occ", 32'(bus.occupancy), 32'(5 - t));
    end
    tick();
    chk("t4_no_sixth", 32'(bus.iss_valid), 0);

    // same-cycle wakeup, then flush
    disp(20, 19, 1);
    bus.cdb_valid = 1'b1; bus.cdb_tag = 19;
    tick();
    bus.ALU_DR = 1'b0; bus.cdb_valid = 1'b0;
    tick();
    chk("t5_wake_valid", 32'(bus.iss_valid), 1);
    chk("t5_wake_no", bus.iss_instr_no, 20);
    bus.iss_ready = 1'b0;
    for (int t = 21; t <= 23; t++) begin
      disp(32'(t), 0, 0);
      tick();
    end
    chk("t5_occ3", 32'(bus.occupancy), 3);
    disp(24, 0, 0);
    bus.flush = 1'b1;
    #1 chk("t5_flush_not_ready", 32'(bus.ALUbuffer_ready), 0);
    tick();
    bus.flush = 1'b0; bus.ALU_DR = 1'b0;
    chk("t5_flush_occ", 32'(bus.occupancy), 0);
    chk("t5_flush_valid", 32'(bus.iss_valid), 0);
    bus.iss_ready = 1'b1;
    tick();
    chk("t5_nothing_stored", 32'(bus.iss_valid), 0);
    chk("t5_occ_still0", 32'(bus.occupancy), 0);

    // asynchronous reset mid-stream
    bus.iss_ready = 1'b0;
    for (int t = 30; t <= 33; t++) begin
      disp(32'(t), 0, 0);
      tick();
    end
    bus.ALU_DR = 1'b0;
    chk("t6_occ3", 32'(bus.occupancy), 3);
    chk("t6_out_no", bus.iss_instr_no, 30);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_occ", 32'(bus.occupancy), 0);
    chk("t6_rst_valid", 32'(bus.iss_valid), 0);
    chk("t6_rst_no", bus.iss_instr_no, 0);
    chk("t6_rst_instr", bus.iss_instr, 0);
    #3 rst = 1'b1;
    #1 chk("t6_ready_after", 32'(bus.ALUbuffer_ready), 1);
    tick();
    chk("t6_idle_valid", 32'(bus.iss_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_issue_buffer.md
# alu_issue_buffer

Reservation buffer at the ALU end of the dispatch interface. It accepts instructions that the control unit dispatches on `ALU_Instr`/`ALU_InstrNO`/`ALU_DR`, and drives `ALUbuffer_ready` back to it. Each entry is held until its source operands are broadcast on the result bus. The oldest ready entry then goes through a registered valid/ready port to the ALU.

## Interface
- `DEPTH`, 4: number of queue entries (2..8).
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: reset, asynchronous and active-low.
- `ALU_Instr  in  32`: dispatched instruction word.
- `ALU_InstrNO  in  32`: sequence number (tag) of the dispatched instruction.
- `ALU_DR  in  1`: dispatch strobe; one instruction per cycle while high.
- `src1_tag  in  32`: producer tag of the rs operand; valid with `ALU_DR`.
- `src1_pend  in  1`: rs producer still in flight.
- `src2_tag  in  32`: producer tag of the rt operand.
- `src2_pend  in  1`: rt producer still in flight (0 for I-type).
- `cdb_valid  in  1`: result broadcast valid.
- `cdb_tag  in  32`: tag of the broadcast result.
- `flush  in  1`: discard all held and output instructions (mispredicted branch).
- `ALUbuffer_ready  out  1`: queue can accept a dispatch this cycle.
- `iss_valid  out  1`: issue output holds an instruction.
- `iss_instr  out  32`: issued instruction word.
- `iss_instr_no  out  32`: issued tag.
- `iss_ready  in  1`: ALU accepts the issue output this cycle.
- `occupancy  out  4`: queue entries in use (the output register is not counted).

## Operation
- Queue is age-compacting: index 0 is the oldest entry. Each entry holds {valid, instr, instr_no, tag1, pend1, tag2, pend2}.
- **Dispatch:** when `ALU_DR && ALUbuffer_ready`, the instruction is written to slot `occupancy` (after compaction for a same-cycle removal).
  - `ALU_DR` with `ALUbuffer_ready`=0 is dropped. It does not change state.
- **Wakeup:** every cycle, for each valid entry, `pendX` clears when `cdb_valid && cdb_tag==tagX`.
  - An instruction dispatched in the same cycle as a matching broadcast is stored with that pend bit already 0.
- **Entry ready** = valid && !pend1 && !pend2.
- **Selection:** the lowest-index ready entry.
- **Output register load:** when `!iss_valid || iss_ready` and a ready entry exists:
  - the selected entry moves into `iss_instr`/`iss_instr_no`;
  - `iss_valid` is set to 1;
  - entries above it shift down one slot, preserving age order.
- **No ready entry:** if `iss_valid && iss_ready` and no entry is ready, `iss_valid` drops to 0.
- **Output hold:** while `iss_valid && !iss_ready`, `iss_instr` and `iss_instr_no` stay stable.
- **Readiness flag:** `ALUbuffer_ready` = (`occupancy` < DEPTH) && !`flush`. It is combinational from registered count. It does not anticipate a same-cycle removal, so a full queue reports not ready even while issuing.
- **Flush:** clears all entry valid bits, `occupancy`, and `iss_valid` at the next edge. Dispatch, wakeup and issue in the same cycle are ignored.
- **Reset values:** all entries invalid; `occupancy`=0; `iss_valid`=0; `iss_instr`=0; `iss_instr_no`=0; `ALUbuffer_ready`=1 once `rst` is released.

## Timing
- Dispatch at edge E → the entry is visible at E. The earliest `iss_valid` is asserted after edge E+1, so the minimum latency is 1 cycle.
- Broadcast at edge E clears pend at E. The entry becomes eligible for the load at edge E+1.
- Issue throughput: one instruction per cycle while `iss_ready`=1 and ready entries exist.
- Simultaneous dispatch and removal: the new entry goes to the slot after compaction, and `occupancy` is unchanged.
- Reset is asynchronous. Asserting `rst` mid-operation clears all state immediately, independent of `clk`.

## Test plan
1. **Basic issue:** reset, then dispatch `ALU_Instr`=0x00221820 with tag 5, no pend, `iss_ready`=1. Required: `iss_valid`=1 one cycle later with `iss_instr_no`=5, and `occupancy` back to 0.
2. **Dependency wait:** dispatch tag 7 with `src1_tag`=3 and `src1_pend`=1. Hold it 3 cycles with no broadcast: `iss_valid` stays 0. Drive `cdb_valid`=1 with `cdb_tag`=3: tag 7 issues on the following edge.
3. **Out-of-order pass:** dispatch tag 10 (pending on 9), then tag 11 (ready). Required: tag 11 issues first and tag 10 stays at index 0. After broadcast of 9, tag 10 issues.
4. **Full/backpressure:** `iss_ready`=0 and DEPTH+1 ready dispatches (tags 1..5). Required:
   - tag 1 in the output register and tags 2..5 queued;
   - `ALUbuffer_ready`=0;
   - a sixth `ALU_DR` is dropped.
   Then raise `iss_ready`: issue order is 1..5.
5. **Flush and same-cycle wakeup:** dispatch tag 20 pending on 19 in the same cycle as a broadcast of 19. Required: tag 20 issues next cycle. Then fill 3 entries and assert `flush` with `ALU_DR`=1. Required: `occupancy`=0 and `iss_valid`=0, and the concurrent dispatch is not stored.
6. **Async reset mid-stream:** with 3 entries held, drop `rst` between clock edges. Required: `occupancy`=0, `iss_valid`=0 and `iss_instr_no`=0 immediately, and `ALUbuffer_ready`=1 after release.
